// File: rtl/bcd_keypad_pkg.sv
// bcd_keypad_pkg: shared FSM state encoding, BCD width and keypad decode helper
package bcd_keypad_pkg;

   localparam int BCD_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      HELD
   } state_e;

   // Returns {valid, bcd}; valid is low for an empty or multi-key pattern.
   function automatic logic [BCD_W:0] onehot10_to_bcd(input logic [9:0] keys);
      logic [BCD_W:0] r;
      r = '0;
      for (int i = 0; i < 10; i++)
         if (keys == 10'(1 << i)) r = {1'b1, BCD_W'(i)};
      return r;
   endfunction

endpackage

// File: rtl/key_sync_debounce.sv
// key_sync_debounce: synchronises raw key lines, debounces press and release, strobes one press per hold
module key_sync_debounce
   import bcd_keypad_pkg::*;
#(
   parameter int DEB_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] key_i,
   output logic       press_stb_o,
   output logic [9:0] press_code_o
);

   localparam int            CW   = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

   logic [9:0]    sync_q, key_s_q;
   logic [9:0]    cand_q, cand_d;
   logic [CW-1:0] cnt_q, cnt_d;
   state_e        state_q, state_d;

   // Two-flop synchroniser for the asynchronous key lines
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         key_s_q <= '0;
      end else begin
         sync_q  <= key_i;
         key_s_q <= sync_q;
      end
   end

   // Debounce FSM registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cand_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: a pattern must persist DEB_CYCLES samples to be accepted, and so must the release
   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      press_stb_o = 1'b0;
      case (state_q)
         IDLE:
            if (key_s_q != '0) begin
               state_d = DEBOUNCE;
               cand_d  = key_s_q;
               cnt_d   = CW'(1);
            end
         DEBOUNCE:
            if (key_s_q == '0) begin
               state_d = IDLE;
            end else if (key_s_q != cand_q) begin
               cand_d = key_s_q;
               cnt_d  = CW'(1);
            end else if (cnt_q == LAST) begin
               state_d     = HELD;
               cnt_d       = '0;
               press_stb_o = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         HELD:
            if (key_s_q != '0) begin
               cnt_d = '0;
            end else if (cnt_q == LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         default: state_d = IDLE;
      endcase
   end

   assign press_code_o = cand_q;

endmodule

// File: rtl/bcd_keypad_entry_ctrl.sv
// bcd_keypad_entry_ctrl: keypad presses to BCD digits, shifted into a number offered by valid/ready
module bcd_keypad_entry_ctrl
   import bcd_keypad_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter int DEB_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [9:0]              key_in,
   input  logic                    clr,
   input  logic                    out_ready,
   output logic [BCD_W-1:0]        bcd_digit,
   output logic                    digit_valid,
   output logic [BCD_W*DIGITS-1:0] number,
   output logic                    number_valid,
   output logic                    multi_err,
   output logic                    overflow
);

   localparam int NW = BCD_W * DIGITS;
   localparam int KW = $clog2(DIGITS + 1);

   logic             press_stb;
   logic [9:0]       press_code;
   logic [BCD_W:0]   dec;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic             dv_q, dv_d, me_q, me_d, ov_q, ov_d, nv_q, nv_d;
   logic [NW-1:0]    num_q, num_d, base;
   logic [KW-1:0]    cnt_q, cnt_d, base_cnt;
   logic             accept, hs, base_nv, load;

   key_sync_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_deb (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_i       (key_in),
      .press_stb_o (press_stb),
      .press_code_o(press_code)
   );

   assign dec = onehot10_to_bcd(press_code);

   // Handshake empties the accumulator first so a same-cycle digit lands in it; clr overrides both
   always_comb begin
      accept   = press_stb && dec[BCD_W];
      hs       = nv_q && out_ready;
      base     = hs ? '0 : num_q;
      base_cnt = hs ? '0 : cnt_q;
      base_nv  = nv_q && !hs;
      load     = accept && !base_nv;
      dv_d     = accept;
      bcd_d    = accept ? dec[BCD_W-1:0] : bcd_q;
      me_d     = press_stb && !dec[BCD_W];
      ov_d     = accept && base_nv && !clr;
      num_d    = clr ? '0 : load ? ((base << BCD_W) | NW'(dec[BCD_W-1:0])) : base;
      cnt_d    = clr ? '0 : load ? base_cnt + KW'(1) : base_cnt;
      nv_d     = !clr && (base_nv || (load && (base_cnt + KW'(1) == KW'(DIGITS))));
   end

   // Output and accumulator registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_q <= '0;
         dv_q  <= 1'b0;
         me_q  <= 1'b0;
         ov_q  <= 1'b0;
         nv_q  <= 1'b0;
         num_q <= '0;
         cnt_q <= '0;
      end else begin
         bcd_q <= bcd_d;
         dv_q  <= dv_d;
         me_q  <= me_d;
         ov_q  <= ov_d;
         nv_q  <= nv_d;
         num_q <= num_d;
         cnt_q <= cnt_d;
      end
   end

   assign bcd_digit    = bcd_q;
   assign digit_valid  = dv_q;
   assign number       = num_q;
   assign number_valid = nv_q;
   assign multi_err    = me_q;
   assign overflow     = ov_q;

endmodule
